q_ifid: RTL



---
 rtl/q_ifid_pkg.sv | 14 +
 rtl/q_ifid_ptr.sv | 38 +++
 rtl/q_ifid.sv | 109 ++++++++++
 3 files changed

// File: rtl/q_ifid_pkg.sv
// rtl/q_ifid_pkg.sv - shared types and constants for the fetch/decode instruction queue
package q_ifid_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = '0;

    typedef struct packed {
        logic [INSTR_W-1:0] instr1;
        logic [INSTR_W-1:0] instr2;
        logic [INSTR_W-1:0] pca;
        logic [INSTR_W-1:0] cia;
    } bundle_t;

endpackage

// File: rtl/q_ifid_ptr.sv
// rtl/q_ifid_ptr.sv - circular pointer that wraps after DEPTH-1, with synchronous clear
module q_ifid_ptr
    import q_ifid_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // DEPTH need not be a power of two, so wrap on an explicit compare.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/q_ifid.sv
// rtl/q_ifid.sv - show-ahead bundle FIFO between fetch and decode with flush and back-pressure
module q_ifid
    import q_ifid_pkg::*;
#(
    parameter  int DEPTH    = 4,
    parameter  int AFULL_TH = 3,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               flush,
    input  logic               pushReq,
    input  logic [INSTR_W-1:0] Instr1_in,
    input  logic [INSTR_W-1:0] Instr2_in,
    input  logic [INSTR_W-1:0] PCA_in,
    input  logic [INSTR_W-1:0] CIA_in,
    input  logic               popReq,
    output logic [INSTR_W-1:0] Instr1_out,
    output logic [INSTR_W-1:0] Instr2_out,
    output logic [INSTR_W-1:0] PCA_out,
    output logic [INSTR_W-1:0] CIA_out,
    output logic               full,
    output logic               almost_full,
    output logic               empty,
    output logic [CNT_W-1:0]   count,
    output logic               overflow_err
);

    bundle_t          mem_q [DEPTH];
    bundle_t          head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             push_ok;
    logic             pop_ok;

    // Status flags come only from the registered count, keeping fetch's
    // stall decision free of any path through this cycle's push/pop.
    assign full        = (count_q == CNT_W'(DEPTH));
    assign almost_full = (count_q >= CNT_W'(AFULL_TH));
    assign empty       = (count_q == '0);

    assign push_ok = pushReq & ~full & ~flush;
    assign pop_ok  = popReq & ~empty & ~flush;

    q_ifid_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .clk_i  (CLK),
        .rst_ni (RESET),
        .clr_i  (flush),
        .inc_i  (push_ok),
        .ptr_o  (wr_ptr)
    );

    q_ifid_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .clk_i  (CLK),
        .rst_ni (RESET),
        .clr_i  (flush),
        .inc_i  (pop_ok),
        .ptr_o  (rd_ptr)
    );

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q | (pushReq & full & ~flush);
        if (flush) begin
            count_d = '0;
        end else if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr] <= '{instr1: Instr1_in, instr2: Instr2_in, pca: PCA_in, cia: CIA_in};
        end
    end

    assign head         = mem_q[rd_ptr];
    assign Instr1_out   = head.instr1;
    assign Instr2_out   = head.instr2;
    assign PCA_out      = head.pca;
    assign CIA_out      = head.cia;
    assign count        = count_q;
    assign overflow_err = ovf_q;

    a_count_bound : assert property (@(posedge CLK) disable iff (!RESET)
        count_q <= CNT_W'(DEPTH));
    a_ptr_span : assert property (@(posedge CLK) disable iff (!RESET)
        ((int'(wr_ptr) - int'(rd_ptr) + DEPTH) % DEPTH) == (int'(count_q) % DEPTH));
    a_full_empty : assert property (@(posedge CLK) disable iff (!RESET)
        !(full && empty));

endmodule
